// File: rtl/mam_wb_package.sv
// Shared types and constants for the MAM-to-Wishbone bridge.
package mam_wb_package;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_WDONE = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Remaining-beat counter and per-segment counter widths
    localparam int unsigned BEAT_W = 13;
    localparam int unsigned SEG_W  = 9;

    // Cycle type for the beat about to be presented
    function automatic logic [2:0] cti_for(input logic burst, input logic [SEG_W-1:0] seg_rem);
        if (!burst)
            return CTI_CLASSIC;
        else if (seg_rem <= SEG_W'(1))
            return CTI_EOB;
        else
            return CTI_INCR;
    endfunction

endpackage

// File: rtl/osd_mam_wb_timeout.sv
// Bus-hang watchdog for the MAM Wishbone bridge.
// Only present when OSD_MAM_WB_TIMEOUT_EN is defined; the bridge has no
// watchdog otherwise, so the module is not built at all in that case.
`ifdef OSD_MAM_WB_TIMEOUT_EN
module osd_mam_wb_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active,
    input  logic restart,
    output logic expire_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Count cycles of an outstanding strobe; any termination or idle bus restarts
    always_ff @(posedge clk_i) begin
        if (!rst_i)
            count <= '0;
        else if (!active || restart)
            count <= '0;
        else
            count <= count + CNT_W'(1);
    end

    assign expire_c = active && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/osd_mam_wb_bridge.sv
// MAM request/data streams to Wishbone B3 classic and incrementing bursts.
// Optional bus-hang timeout: define OSD_MAM_WB_TIMEOUT_EN.
module osd_mam_wb_bridge
    import mam_wb_package::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned BURST_MAX      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic                      req_burst,
    input  logic [12:0]               req_beats,
    input  logic                      req_sync,

    input  logic                      write_valid,
    output logic                      write_ready,
    input  logic [DATA_WIDTH-1:0]     write_data,
    input  logic [DATA_WIDTH/8-1:0]   write_strb,
    output logic                      write_complete,

    output logic                      read_valid,
    input  logic                      read_ready,
    output logic [DATA_WIDTH-1:0]     read_data,

    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [DATA_WIDTH-1:0]     dat_o,
    input  logic [DATA_WIDTH-1:0]     dat_i,
    output logic [DATA_WIDTH/8-1:0]   sel_o,
    output logic [2:0]                cti_o,
    output logic [1:0]                bte_o,
    input  logic                      ack_i,
    input  logic                      err_i,
    output logic                      bus_err_o
);

    localparam int unsigned SW = DATA_WIDTH / 8;

    // Elaboration-time parameter sanity
    if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
        $error("osd_mam_wb_bridge: DATA_WIDTH must be 8, 16, 32 or 64");
    end
    if (BURST_MAX < 1 || BURST_MAX > 256 || (BURST_MAX & (BURST_MAX - 1)) != 0) begin : g_bad_burst
        $error("osd_mam_wb_bridge: BURST_MAX must be a power of two in 1..256");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("osd_mam_wb_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    state_t             state;
    logic [BEAT_W-1:0]  beats_rem;
    logic [SEG_W-1:0]   seg_rem;
    logic               burst_q;
    logic               abort;
    logic               expire;

    logic [BEAT_W-1:0]  beats_dec;
    logic [BEAT_W-1:0]  beats_n;
    logic [BEAT_W-1:0]  beats_init;
    logic [SEG_W-1:0]   seg_reload;
    logic [SEG_W-1:0]   seg_next;
    logic [SEG_W-1:0]   seg_init;
    logic               have_beats;
    logic               rd_slot;
    logic               term;
    logic               term_err;
    logic               drain;
    logic               step;
    logic               rd_full_n;

    // Synchronous writes finish like any other write here
    logic unused_sync;
    assign unused_sync = req_sync;

    assign have_beats = (beats_rem != '0);
    assign rd_slot    = !read_valid || read_ready;

    // Strobe is live only while the bus owns a beat and its data/space is available
    assign stb_o = cyc_o && !abort && have_beats &&
                   (((state == ST_READ) && rd_slot) || ((state == ST_WRITE) && write_valid));

    assign term     = stb_o && (ack_i || err_i || expire);
    assign term_err = stb_o && (err_i || expire);
    assign drain    = abort && have_beats &&
                      (((state == ST_READ) && rd_slot) || ((state == ST_WRITE) && write_valid));
    assign step     = term || drain;

    assign write_ready = (state == ST_WRITE) && step;
    assign dat_o       = (state == ST_WRITE) ? write_data : '0;
    assign sel_o       = (state == ST_READ)  ? {SW{1'b1}} :
                         (state == ST_WRITE) ? write_strb : '0;
    assign bte_o       = BTE_LINEAR;

    // Beat and segment bookkeeping for the next terminated beat
    always_comb begin
        beats_dec  = beats_rem - BEAT_W'(1);
        beats_n    = step ? beats_dec : beats_rem;
        seg_reload = (beats_dec > BEAT_W'(BURST_MAX)) ? SEG_W'(BURST_MAX) : SEG_W'(beats_dec);
        seg_next   = (seg_rem == SEG_W'(1)) ? seg_reload : (seg_rem - SEG_W'(1));
        beats_init = (!req_burst || req_beats == '0) ? BEAT_W'(1) : req_beats;
        seg_init   = (beats_init > BEAT_W'(BURST_MAX)) ? SEG_W'(BURST_MAX) : SEG_W'(beats_init);
        rd_full_n  = step || (read_valid && !read_ready);
    end

`ifdef OSD_MAM_WB_TIMEOUT_EN
    osd_mam_wb_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .active   (stb_o),
        .restart  (stb_o && (ack_i || err_i)),
        .expire_c (expire)
    );
`else
    assign expire = 1'b0;
`endif

    // Request FSM with registered Wishbone/MAM outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            cyc_o          <= 1'b0;
            we_o           <= 1'b0;
            addr_o         <= '0;
            cti_o          <= CTI_CLASSIC;
            beats_rem      <= '0;
            seg_rem        <= '0;
            burst_q        <= 1'b0;
            read_valid     <= 1'b0;
            read_data      <= '0;
            bus_err_o      <= 1'b0;
            write_complete <= 1'b0;
            abort          <= 1'b0;
        end else begin
            write_complete <= 1'b0;

            if (step) begin
                addr_o    <= addr_o + ADDR_WIDTH'(SW);
                beats_rem <= beats_dec;
                seg_rem   <= seg_next;
                cti_o     <= cti_for(burst_q, seg_next);
                if (term_err)
                    bus_err_o <= 1'b1;
            end

            if (expire) begin
                abort <= 1'b1;
                cyc_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        addr_o    <= req_addr;
                        beats_rem <= beats_init;
                        seg_rem   <= seg_init;
                        burst_q   <= req_burst;
                        cti_o     <= cti_for(req_burst, seg_init);
                        bus_err_o <= 1'b0;
                        abort     <= 1'b0;
                        req_ready <= 1'b0;
                        cyc_o     <= 1'b1;
                        we_o      <= req_we;
                        state     <= req_we ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    if (step)
                        read_data <= (term && !term_err) ? dat_i : '0;
                    read_valid <= rd_full_n;
                    if (beats_n == '0 && !rd_full_n) begin
                        state     <= ST_IDLE;
                        cyc_o     <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (step && beats_rem == BEAT_W'(1)) begin
                        state          <= ST_WDONE;
                        cyc_o          <= 1'b0;
                        we_o           <= 1'b0;
                        write_complete <= 1'b1;
                    end
                end
                ST_WDONE: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
